// File: rtl/memory_access_stage.sv
// Pipeline memory stage: valid/ready memory port, sub-word loads/stores with byte
// enables, misalignment suppression, a backpressured output register and a forwarding tuple.
module memory_access_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [1:0]              in_size,
  input  logic                    in_sign_extend,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic [DATA_WIDTH-1:0]   in_store_data,
  input  logic                    in_reg_write_enable,
  input  logic [REG_ID_WIDTH-1:0] in_reg_write_id,
  input  logic                    in_reg_write_ready,
  input  logic [DATA_WIDTH-1:0]   in_reg_write_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_address,
  output logic [DATA_WIDTH-1:0]   mem_req_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_req_byte_enable,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_reg_write_enable,
  output logic [REG_ID_WIDTH-1:0] out_reg_write_id,
  output logic [DATA_WIDTH-1:0]   out_reg_write_data,
  output logic                    out_misaligned,
  output logic [REG_ID_WIDTH-1:0] fwd_register_id,
  output logic                    fwd_data_ready,
  output logic [DATA_WIDTH-1:0]   fwd_data
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESP, COMPLETE} state_e;
  state_e state_q, state_d;

  // hold register for the in-flight memory instruction
  logic                    h_write_q, h_write_d;
  logic [1:0]              h_size_q, h_size_d;
  logic                    h_sign_q, h_sign_d;
  logic [OFFW-1:0]         h_off_q, h_off_d;
  logic [ADDR_WIDTH-1:0]   h_addr_q, h_addr_d;
  logic [DATA_WIDTH-1:0]   h_wdata_q, h_wdata_d;
  logic [NB-1:0]           h_be_q, h_be_d;
  logic                    h_we_q, h_we_d;
  logic [REG_ID_WIDTH-1:0] h_id_q, h_id_d;
  logic [DATA_WIDTH-1:0]   h_data_q, h_data_d;

  // output register
  logic                    o_vld_q, o_vld_d;
  logic                    o_we_q, o_we_d;
  logic [REG_ID_WIDTH-1:0] o_id_q, o_id_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
  logic                    o_mis_q, o_mis_d;

  logic                  slot_free, accept, is_mem, misaligned;
  logic [OFFW-1:0]       in_off;
  logic [NB-1:0]         be_base;
  logic [DATA_WIDTH-1:0] sh, mask, ld_data;
  logic                  ld_msb;

  assign slot_free = !o_vld_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_mem    = in_mem_read || in_mem_write;
  assign in_off    = in_address[OFFW-1:0];

  always_comb begin
    misaligned = 1'b0;
    be_base    = '1;
    case (in_size)
      2'd0: be_base = NB'(1);
      2'd1: begin be_base = NB'(3);     misaligned = in_address[0];      end
      2'd2: begin be_base = NB'(8'h0F); misaligned = |in_address[1:0]; end
      default: misaligned = (DATA_WIDTH != 64) || (|in_address[2:0]);
    endcase
  end

  // load extraction: align to lane 0, truncate, then extend
  always_comb begin
    sh = mem_resp_data >> {h_off_q, 3'b000};
    case (h_size_q)
      2'd0:    begin mask = DATA_WIDTH'(8'hFF);         ld_msb = sh[7];  end
      2'd1:    begin mask = DATA_WIDTH'(16'hFFFF);      ld_msb = sh[15]; end
      2'd2:    begin mask = DATA_WIDTH'(32'hFFFF_FFFF); ld_msb = sh[31]; end
      default: begin mask = '1;                         ld_msb = sh[DATA_WIDTH-1]; end
    endcase
    ld_data = (sh & mask) | ((h_sign_q && ld_msb) ? ~mask : '0);
  end

  always_comb begin
    state_d   = state_q;
    h_write_d = h_write_q; h_size_d = h_size_q; h_sign_d = h_sign_q;
    h_off_d   = h_off_q;   h_addr_d = h_addr_q; h_wdata_d = h_wdata_q;
    h_be_d    = h_be_q;    h_we_d   = h_we_q;   h_id_d   = h_id_q;
    h_data_d  = h_data_q;
    o_vld_d   = o_vld_q && !out_ready;
    o_we_d    = o_we_q; o_id_d = o_id_q; o_data_d = o_data_q; o_mis_d = o_mis_q;
    case (state_q)
      IDLE: if (accept) begin
        if (!is_mem) begin
          o_vld_d  = 1'b1;
          o_we_d   = in_reg_write_enable;
          o_id_d   = in_reg_write_id;
          o_data_d = (in_reg_write_enable && in_reg_write_ready) ? in_reg_write_data : '0;
          o_mis_d  = 1'b0;
        end else if (misaligned) begin
          o_vld_d  = 1'b1;
          o_we_d   = 1'b0;
          o_id_d   = in_reg_write_id;
          o_data_d = '0;
          o_mis_d  = 1'b1;
        end else begin
          h_write_d = in_mem_write;
          h_size_d  = in_size;
          h_sign_d  = in_sign_extend;
          h_off_d   = in_off;
          h_addr_d  = {in_address[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
          h_wdata_d = in_store_data << {in_off, 3'b000};
          h_be_d    = in_mem_write ? (be_base << in_off) : '1;
          h_we_d    = in_reg_write_enable;
          h_id_d    = in_reg_write_id;
          h_data_d  = in_reg_write_enable ? in_reg_write_data : '0;
          state_d   = REQUEST;
        end
      end
      REQUEST: if (mem_req_ready) state_d = h_write_q ? COMPLETE : WAIT_RESP;
      WAIT_RESP: if (mem_resp_valid) begin
        h_data_d = ld_data;
        state_d  = COMPLETE;
      end
      default: if (slot_free) begin
        o_vld_d  = 1'b1;
        o_we_d   = h_we_q;
        o_id_d   = h_id_q;
        o_data_d = h_data_q;
        o_mis_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      h_write_q <= 1'b0; h_size_q <= '0; h_sign_q <= 1'b0; h_off_q <= '0;
      h_addr_q  <= '0;   h_wdata_q <= '0; h_be_q <= '0;    h_we_q <= 1'b0;
      h_id_q    <= '0;   h_data_q <= '0;
      o_vld_q   <= 1'b0; o_we_q <= 1'b0; o_id_q <= '0; o_data_q <= '0; o_mis_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_write_q <= h_write_d; h_size_q <= h_size_d; h_sign_q <= h_sign_d; h_off_q <= h_off_d;
      h_addr_q  <= h_addr_d;  h_wdata_q <= h_wdata_d; h_be_q <= h_be_d;   h_we_q <= h_we_d;
      h_id_q    <= h_id_d;    h_data_q <= h_data_d;
      o_vld_q   <= o_vld_d; o_we_q <= o_we_d; o_id_q <= o_id_d; o_data_q <= o_data_d;
      o_mis_q   <= o_mis_d;
    end
  end

  assign mem_req_valid       = (state_q == REQUEST);
  assign mem_req_write       = h_write_q;
  assign mem_req_address     = h_addr_q;
  assign mem_req_write_data  = h_wdata_q;
  assign mem_req_byte_enable = h_be_q;

  assign out_valid            = o_vld_q;
  assign out_reg_write_enable = o_we_q;
  assign out_reg_write_id     = o_id_q;
  assign out_reg_write_data   = o_data_q;
  assign out_misaligned       = o_mis_q;

  assign fwd_data_ready  = 1'b1;
  assign fwd_register_id = (o_vld_q && o_we_q) ? o_id_q : '0;
  assign fwd_data        = (o_vld_q && o_we_q) ? o_data_q : '0;

  // an ALU result that claims to write but is not yet final cannot be forwarded
  a_alu_data_final: assert property (@(posedge clock) disable iff (reset)
    !(accept && !is_mem && in_reg_write_enable && !in_reg_write_ready));
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage (DATA_WIDTH=32): passthrough, sub-word
// load/store, misalignment, output backpressure and reset mid-transaction.
module tb_memory_access_stage;
  logic        clock, reset;
  logic        in_valid, in_ready, in_mem_read, in_mem_write, in_sign_extend;
  logic [1:0]  in_size;
  logic [31:0] in_address, in_store_data, in_reg_write_data;
  logic        in_reg_write_enable, in_reg_write_ready;
  logic [4:0]  in_reg_write_id;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_address, mem_req_write_data;
  logic [3:0]  mem_req_byte_enable;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid, out_ready, out_reg_write_enable, out_misaligned;
  logic [4:0]  out_reg_write_id, fwd_register_id;
  logic [31:0] out_reg_write_data, fwd_data;
  logic        fwd_data_ready;

  int n_tests = 0;
  int n_fail  = 0;

  memory_access_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_sign_extend(in_sign_extend),
    .in_address(in_address), .in_store_data(in_store_data),
    .in_reg_write_enable(in_reg_write_enable), .in_reg_write_id(in_reg_write_id),
    .in_reg_write_ready(in_reg_write_ready), .in_reg_write_data(in_reg_write_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_address(mem_req_address),
    .mem_req_write_data(mem_req_write_data), .mem_req_byte_enable(mem_req_byte_enable),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write_enable(out_reg_write_enable), .out_reg_write_id(out_reg_write_id),
    .out_reg_write_data(out_reg_write_data), .out_misaligned(out_misaligned),
    .fwd_register_id(fwd_register_id), .fwd_data_ready(fwd_data_ready), .fwd_data(fwd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs are changed and outputs sampled near the negedge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic offer(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic we,
                       input logic [4:0] id, input logic [31:0] wdata);
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_size = sz;
    in_sign_extend = sx; in_address = addr; in_store_data = sdata;
    in_reg_write_enable = we; in_reg_write_id = id; in_reg_write_ready = 1'b1;
    in_reg_write_data = wdata;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle_in();
    in_size = 2'd0; in_sign_extend = 1'b0; in_address = '0; in_store_data = '0;
    in_reg_write_enable = 1'b0; in_reg_write_id = '0; in_reg_write_ready = 1'b1;
    in_reg_write_data = '0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    mem_resp_data = '0; out_ready = 1'b1;
    @(negedge clock); #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_data", out_reg_write_data, 0);
    chk("rst fwd_id", fwd_register_id, 0);
    chk("rst fwd_ready", fwd_data_ready, 1);
    chk("rst fwd_data", fwd_data, 0);
    @(negedge clock); reset = 1'b0; #1;

    // ALU passthrough, latency 1
    offer(0, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd3, 32'h1234);
    #1 chk("alu in_ready", in_ready, 1);
    step(); idle_in();
    chk("alu out_valid", out_valid, 1);
    chk("alu out_id", out_reg_write_id, 3);
    chk("alu out_data", out_reg_write_data, 32'h1234);
    chk("alu out_we", out_reg_write_enable, 1);
    chk("alu fwd_id", fwd_register_id, 3);
    chk("alu fwd_data", fwd_data, 32'h1234);
    step();
    chk("alu drained", out_valid, 0);
    chk("drained fwd_id", fwd_register_id, 0);

    // signed byte load at 0x103, two wait cycles before the response
    offer(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 5'd5, 32'h0);
    step(); idle_in();
    chk("lb req_valid", mem_req_valid, 1);
    chk("lb req_addr", mem_req_address, 32'h100);
    chk("lb req_write", mem_req_write, 0);
    chk("lb req_be", mem_req_byte_enable, 4'hF);
    chk("lb in_ready busy", in_ready, 0);
    step();
    chk("lb req dropped", mem_req_valid, 0);
    step();
    chk("lb wait in_ready", in_ready, 0);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF_FF00;
    step(); mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    chk("lb complete out_valid", out_valid, 0);
    chk("lb complete in_ready", in_ready, 0);
    step();
    chk("lb out_valid", out_valid, 1);
    chk("lb out_data", out_reg_write_data, 32'hFFFF_FF80);
    chk("lb out_id", out_reg_write_id, 5);
    chk("lb out_we", out_reg_write_enable, 1);
    chk("lb in_ready idle", in_ready, 1);

    // half store at 0x102, memory stalls one cycle
    mem_req_ready = 1'b0;
    offer(0, 1, 2'd1, 0, 32'h102, 32'h0000_ABCD, 0, 5'd0, 32'h0);
    step(); idle_in();
    chk("sh req_valid", mem_req_valid, 1);
    chk("sh req_write", mem_req_write, 1);
    chk("sh req_addr", mem_req_address, 32'h100);
    chk("sh req_be", mem_req_byte_enable, 4'b1100);
    chk("sh req_wdata", mem_req_write_data, 32'hABCD_0000);
    step();
    chk("sh req held", mem_req_valid, 1);
    chk("sh be held", mem_req_byte_enable, 4'b1100);
    mem_req_ready = 1'b1;
    step();
    chk("sh req done", mem_req_valid, 0);
    step();
    chk("sh out_valid", out_valid, 1);
    chk("sh out_we", out_reg_write_enable, 0);
    chk("sh out_mis", out_misaligned, 0);
    chk("sh fwd_id", fwd_register_id, 0);

    // misaligned word load at 0x101: no request
    offer(1, 0, 2'd2, 0, 32'h101, 32'h0, 1, 5'd6, 32'h0);
    #1 chk("mis no req pre", mem_req_valid, 0);
    step(); idle_in();
    chk("mis no req", mem_req_valid, 0);
    chk("mis out_valid", out_valid, 1);
    chk("mis flag", out_misaligned, 1);
    chk("mis out_we", out_reg_write_enable, 0);
    chk("mis in_ready", in_ready, 1);

    // doubleword on a 32-bit datapath is always misaligned
    offer(1, 0, 2'd3, 0, 32'h100, 32'h0, 1, 5'd6, 32'h0);
    step(); idle_in();
    chk("dw32 no req", mem_req_valid, 0);
    chk("dw32 mis flag", out_misaligned, 1);

    // zero-extended half load at 0x10A, then hold the result under backpressure
    offer(1, 0, 2'd1, 0, 32'h10A, 32'h0, 1, 5'd7, 32'h0);
    step(); idle_in();
    chk("lhu req_addr", mem_req_address, 32'h108);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h8001_2345;
    step(); mem_resp_valid = 1'b0;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      offer(0, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd9, 32'h99);
      #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp out_data", out_reg_write_data, 32'h0000_8001);
      chk("bp in_ready", in_ready, 0);
      step();
    end
    idle_in(); out_ready = 1'b1;
    #1 chk("bp release in_ready", in_ready, 1);
    step();
    chk("bp drained", out_valid, 0);

    // reset while waiting for a response; the late response is dropped
    offer(1, 0, 2'd2, 0, 32'h10C, 32'h0, 1, 5'd9, 32'h0);
    step(); idle_in();
    step();
    chk("rw req done", mem_req_valid, 0);
    chk("rw in_ready busy", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rw rst out_valid", out_valid, 0);
    chk("rw rst req_valid", mem_req_valid, 0);
    step();
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    step(); mem_resp_valid = 1'b0;
    step();
    chk("rw resp ignored", out_valid, 0);
    chk("rw in_ready", in_ready, 1);
    offer(0, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd4, 32'h55);
    step(); idle_in();
    chk("rw next out_valid", out_valid, 1);
    chk("rw next out_id", out_reg_write_id, 4);
    chk("rw next out_data", out_reg_write_data, 32'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
